// File: rtl/int_ram_pingpong_ctrl.sv
//------------------------------------------------------------------------------
// int_ram_pingpong_ctrl : ping-pong controller for the two-bank INT_RAM,
// writing one frame into a bank while streaming the previous frame out.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module int_ram_pingpong_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int FRAME_LEN  = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic [1:0]            ram_cs,
    output logic [1:0]            ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr1,
    output logic [ADDR_WIDTH-1:0] ram_addr2,
    output logic [DATA_WIDTH-1:0] ram_din1,
    output logic [DATA_WIDTH-1:0] ram_din2,
    input  logic [DATA_WIDTH-1:0] ram_dout1,
    input  logic [DATA_WIDTH-1:0] ram_dout2
);

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_e;

    localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(FRAME_LEN - 1);

    bank_state_e           r_bank     [2];
    bank_state_e           w_bank_nxt [2];
    logic                  r_wr_sel;
    logic                  r_rd_sel;
    logic                  r_pop_sel;
    logic                  r_in_ready;
    logic [ADDR_WIDTH-1:0] r_wr_cnt;
    logic [ADDR_WIDTH-1:0] r_rd_cnt;
    logic                  r_inflight;
    logic                  r_inflight_bank;
    logic                  r_inflight_last;
    logic [DATA_WIDTH-1:0] r_fifo_data [2];
    logic [1:0]            r_fifo_last;
    logic                  r_wptr;
    logic                  r_rptr;
    logic [1:0]            r_occ;

    logic                  w_wr_acc;
    logic                  w_wr_wrap;
    logic                  w_wr_sel_nxt;
    logic                  w_in_ready_nxt;
    logic                  w_rd_active;
    logic                  w_rd_issue;
    logic                  w_rd_wrap;
    logic                  w_pop;
    logic                  w_pop_last;
    logic [1:0]            w_credit;

    assign w_wr_acc     = in_valid & r_in_ready;
    assign w_wr_wrap    = w_wr_acc && (r_wr_cnt == c_last_addr);
    assign w_wr_sel_nxt = r_wr_sel ^ w_wr_wrap;

    // A DRAINING bank with rd_cnt back at 0 has had every read issued; only
    // its tail is still in the FIFO, so the reader must not re-enter it.
    assign w_rd_active = (r_bank[r_rd_sel] == FULL) ||
                         ((r_bank[r_rd_sel] == DRAINING) && (r_rd_cnt != '0));

    assign w_pop      = (r_occ != 2'd0) && out_ready;
    assign w_pop_last = w_pop && r_fifo_last[r_rptr];
    assign w_credit   = r_occ + {1'b0, r_inflight};
    // A same-cycle pop frees a slot, which keeps the stream gap-free.
    assign w_rd_issue = w_rd_active && ((w_credit < 2'd2) || w_pop);
    assign w_rd_wrap  = w_rd_issue && (r_rd_cnt == c_last_addr);

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            w_bank_nxt[b] = r_bank[b];
            if (w_wr_acc && (r_wr_sel == 1'(b))) begin
                w_bank_nxt[b] = w_wr_wrap ? FULL : FILLING;
            end
            if (w_rd_issue && (r_rd_sel == 1'(b)) && (r_bank[b] == FULL)) begin
                w_bank_nxt[b] = DRAINING;
            end
            if (w_pop_last && (r_pop_sel == 1'(b))) begin
                w_bank_nxt[b] = EMPTY;
            end
        end
    end

    assign w_in_ready_nxt = (w_bank_nxt[w_wr_sel_nxt] == EMPTY) ||
                            (w_bank_nxt[w_wr_sel_nxt] == FILLING);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                r_bank[b]      <= EMPTY;
                r_fifo_data[b] <= '0;
            end
            r_wr_sel        <= 1'b0;
            r_rd_sel        <= 1'b0;
            r_pop_sel       <= 1'b0;
            r_in_ready      <= 1'b0;
            r_wr_cnt        <= '0;
            r_rd_cnt        <= '0;
            r_inflight      <= 1'b0;
            r_inflight_bank <= 1'b0;
            r_inflight_last <= 1'b0;
            r_fifo_last     <= '0;
            r_wptr          <= 1'b0;
            r_rptr          <= 1'b0;
            r_occ           <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                r_bank[b] <= w_bank_nxt[b];
            end
            r_in_ready <= w_in_ready_nxt;
            r_wr_sel   <= w_wr_sel_nxt;
            if (w_wr_acc) begin
                r_wr_cnt <= w_wr_wrap ? '0 : r_wr_cnt + ADDR_WIDTH'(1);
            end
            if (w_rd_issue) begin
                r_rd_cnt <= w_rd_wrap ? '0 : r_rd_cnt + ADDR_WIDTH'(1);
            end
            if (w_rd_wrap) begin
                r_rd_sel <= ~r_rd_sel;
            end
            if (w_pop_last) begin
                r_pop_sel <= ~r_pop_sel;
            end
            // The bank tag travels with the read because rd_sel may already
            // have toggled by the time the data returns.
            r_inflight      <= w_rd_issue;
            r_inflight_bank <= r_rd_sel;
            r_inflight_last <= w_rd_wrap;
            if (r_inflight) begin
                r_fifo_data[r_wptr] <= r_inflight_bank ? ram_dout2 : ram_dout1;
                r_fifo_last[r_wptr] <= r_inflight_last;
                r_wptr              <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_occ <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end

    always_comb begin
        ram_cs = '0;
        ram_we = '0;
        if (w_wr_acc) begin
            ram_cs[r_wr_sel] = 1'b1;
            ram_we[r_wr_sel] = 1'b1;
        end
        if (w_rd_issue) begin
            ram_cs[r_rd_sel] = 1'b1;
        end
        ram_addr1 = '0;
        ram_addr2 = '0;
        if (w_rd_active && !r_rd_sel) begin
            ram_addr1 = r_rd_cnt;
        end else if (!r_wr_sel) begin
            ram_addr1 = r_wr_cnt;
        end
        if (w_rd_active && r_rd_sel) begin
            ram_addr2 = r_rd_cnt;
        end else if (r_wr_sel) begin
            ram_addr2 = r_wr_cnt;
        end
        ram_din1 = (w_wr_acc && !r_wr_sel) ? in_data : '0;
        ram_din2 = (w_wr_acc &&  r_wr_sel) ? in_data : '0;
    end

    assign in_ready  = r_in_ready;
    assign out_valid = (r_occ != 2'd0);
    assign out_data  = r_fifo_data[r_rptr];
    assign out_last  = out_valid & r_fifo_last[r_rptr];

endmodule

`default_nettype wire
